// File: rtl/icache_refill_axi.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_axi
// Description : Instruction-cache refill engine. Accepts a held miss request
//               from the ICache controller and issues one AXI4 INCR burst read
//               for the whole line. It collects the beats into a line buffer,
//               then returns the line with a single-cycle o_mem_ready pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LINE_WORDS : words per cache line (power of 2, 2..16); also burst length
//   AXI_ID     : constant value driven on o_arid
// Ports
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   i_mem_valid   : refill request, held until o_mem_ready
//   i_mem_addr    : miss address, any byte offset
//   o_mem_ready   : one-cycle pulse; o_line_data / o_line_err valid
//   o_line_data   : assembled line, word i at [32i+31:32i]
//   o_line_err    : error response seen or misplaced rlast during the burst
//   o_ar*         : AXI4 read-address channel (master side)
//   i_r*, o_rready: AXI4 read-data channel (master side)
// ============================================================================
module icache_refill_axi #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] AXI_ID     = 4'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  // controller side
  input  logic                    i_mem_valid,
  input  logic [31:0]             i_mem_addr,
  output logic                    o_mem_ready,
  output logic [32*LINE_WORDS-1:0] o_line_data,
  output logic                    o_line_err,
  // AXI read-address channel
  output logic [3:0]              o_arid,
  output logic [31:0]             o_araddr,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  // AXI read-data channel
  input  logic [3:0]              i_rid,
  input  logic [31:0]             i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rlast,
  input  logic                    i_rvalid,
  output logic                    o_rready
);

  // Byte-offset bits inside one line, and beat counter width. The counter
  // has one spare bit so it reaches LINE_WORDS without wrapping.
  localparam int c_OFF_BITS = $clog2(LINE_WORDS) + 2;
  localparam int c_BEAT_W   = $clog2(LINE_WORDS) + 1;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_araddr;
  logic [c_BEAT_W-1:0]   r_beat;
  logic                  r_err;
  logic                  w_beat_fire;
  logic                  w_last_beat;
  logic                  w_unused;

  // rid is not checked (single outstanding transaction); the low address
  // bits are dropped by line alignment.
  assign w_unused = ^{i_rid, i_mem_addr[c_OFF_BITS-1:0]};

  // rready is decoded from state, so a beat is accepted whenever rvalid is
  // seen in DATA.
  assign w_beat_fire = (r_state == S_DATA) && i_rvalid;
  assign w_last_beat = (r_beat == c_LAST_BEAT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Completion is decided by the beat counter, never by
  // rlast, so a misplaced rlast only flags an error.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_mem_valid) begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (i_arready) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_beat_fire && w_last_beat) begin
          w_state_nxt = S_DONE;
        end
      end
      // DONE always returns to IDLE: mem_valid is still high here and must
      // not start a second refill.
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address latch, beat counter and sticky error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_araddr <= '0;
      r_beat   <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_mem_valid) begin
            r_araddr <= {i_mem_addr[31:c_OFF_BITS], {c_OFF_BITS{1'b0}}};
            r_beat   <= '0;
            r_err    <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_beat_fire) begin
            r_beat <= r_beat + c_BEAT_W'(1);
            if ((i_rresp != 2'b00) || (i_rlast != w_last_beat)) begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Line buffer: one register per word, written by the beat whose index
  // matches. Words keep their value until the next refill overwrites them.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [31:0] r_word;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_word <= '0;
        end else if (w_beat_fire && (r_beat == c_BEAT_W'(gi))) begin
          r_word <= i_rdata;
        end
      end

      assign o_line_data[32*gi +: 32] = r_word;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs: handshake signals decoded from state, the rest registered or
  // constant.
  // --------------------------------------------------------------------------
  assign o_arvalid   = (r_state == S_ADDR);
  assign o_rready    = (r_state == S_DATA);
  assign o_mem_ready = (r_state == S_DONE);
  assign o_line_err  = r_err;
  assign o_araddr    = r_araddr;
  assign o_arid      = AXI_ID;
  assign o_arlen     = 8'(LINE_WORDS - 1);
  assign o_arsize    = 3'b010;
  assign o_arburst   = 2'b01;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_axi.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_axi
// Description : Self-checking bench for icache_refill_axi. A procedural AXI
//               slave feeds each burst. The expected line, error flag, aligned
//               address and mem_ready latency are computed from the request
//               and the stimulus the bench itself chose.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_axi;

  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_valid;
  logic [31:0]     mem_addr;
  logic            mem_ready;
  logic [32*LW-1:0] line_data;
  logic            line_err;
  logic [3:0]      arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [3:0]      rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache_refill_axi #(
    .LINE_WORDS (LW),
    .AXI_ID     (4'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_mem_valid (mem_valid),
    .i_mem_addr  (mem_addr),
    .o_mem_ready (mem_ready),
    .o_line_data (line_data),
    .o_line_err  (line_err),
    .o_arid      (arid),
    .o_araddr    (araddr),
    .o_arlen     (arlen),
    .o_arsize    (arsize),
    .o_arburst   (arburst),
    .o_arvalid   (arvalid),
    .i_arready   (arready),
    .i_rid       (rid),
    .i_rdata     (rdata),
    .i_rresp     (rresp),
    .i_rlast     (rlast),
    .i_rvalid    (rvalid),
    .o_rready    (rready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One refill. gap_mode: 0 = rvalid continuous, 1 = alternating 1/0,
  // 2 = random gaps. err_beat: beat with a non-OKAY response (-1 none).
  // rlast_beat: beat carrying rlast (LW-1 correct, anything else misplaced
  // or missing). Outputs are sampled 1 time unit after the rising edge.
  task automatic refill(input logic [31:0] addr, input int ar_stall, input int gap_mode,
                        input int err_beat, input int rlast_beat, input bit fixed_data);
    logic [31:0]  data [LW];
    logic [127:0] exp_line;
    logic [31:0]  exp_addr;
    bit           exp_err;
    int           cyc, ar_wait, sent, gaps;
    bit           alt, done, give;

    exp_addr = addr & ~32'(LW*4 - 1);
    for (int i = 0; i < LW; i++) begin
      data[i] = fixed_data ? 32'(32'hA0 + i) : $urandom;
      exp_line[32*i +: 32] = data[i];
    end
    exp_err = (err_beat >= 0 && err_beat < LW) || (rlast_beat != LW - 1);

    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    cyc = 0; ar_wait = 0; sent = 0; gaps = 0; alt = 1'b0; done = 1'b0;

    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_ready) begin
        done = 1'b1;
        chk("latency", 128'(cyc), 128'(LW + 2 + ar_stall + gaps));
        chk("line_data", line_data, exp_line);
        chk("line_err", 128'(line_err), 128'(exp_err));
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
      end else begin
        if (arvalid) begin
          chk("araddr", 128'(araddr), 128'(exp_addr));
          arready = (ar_wait >= ar_stall);
          if (!arready) begin
            ar_wait++;
          end else begin
            chk("ar_consts", 128'({arid, arlen, arsize, arburst}),
                128'({4'h0, 8'(LW - 1), 3'b010, 2'b01}));
          end
        end else begin
          arready = 1'b0;
        end
        if (rready && sent < LW) begin
          case (gap_mode)
            0:       give = 1'b1;
            1:       give = !alt;
            default: give = ($urandom_range(0, 2) != 0);
          endcase
          alt = !alt;
          rid = 4'($urandom);
          if (give) begin
            rvalid = 1'b1;
            rdata  = data[sent];
            rresp  = (sent == err_beat) ? 2'($urandom_range(1, 3)) : 2'b00;
            rlast  = (sent == rlast_beat);
            sent++;
          end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'($urandom);
            rlast  = 1'b0;
            gaps++;
          end
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end
      end
    end

    if (!done) begin
      chk("timeout", 128'(0), 128'(1));
      mem_valid = 1'b0;
    end else begin
      // mem_valid stays high through the DONE cycle; the next cycle must be
      // a quiet IDLE with no second pulse and no new address phase.
      @(posedge clk); #1;
      chk("pulse_once", 128'(mem_ready), 128'(0));
      chk("no_rearm", 128'(arvalid), 128'(0));
      mem_valid = 1'b0;
    end
  endtask

  // Start a refill, deliver beats 0 and 1, then reset.
  task automatic reset_mid_burst();
    int k;
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = $urandom;
    k = 0;
    while (!arvalid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chk("rst_pre_rready", 128'(rready), 128'(1));
    rvalid = 1'b1; rresp = 2'b00; rlast = 1'b0; rdata = $urandom | 32'h1;
    @(posedge clk); #1;
    rdata = $urandom | 32'h1;
    @(posedge clk); #1;
    rvalid = 1'b0; mem_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_rready", 128'(rready), 128'(0));
    chk("rst_arvalid", 128'(arvalid), 128'(0));
    chk("rst_mem_ready", 128'(mem_ready), 128'(0));
    chk("rst_line_data", line_data, 128'(0));
    chk("rst_line_err", 128'(line_err), 128'(0));
    chk("rst_araddr", 128'(araddr), 128'(0));
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_addr = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 128'({mem_ready, arvalid, rready, line_err}), 128'(0));
    chk("reset_araddr", 128'(araddr), 128'(0));
    chk("reset_line", line_data, 128'(0));
    chk("reset_consts", 128'({arid, arlen, arsize, arburst}),
        128'({4'h0, 8'(LW - 1), 3'b010, 2'b01}));
    rst = 1'b0;

    // basic refill with known data
    refill(32'h1C00_0014, 0, 0, -1, LW - 1, 1'b1);
    // AR stall of 3 plus alternating rvalid
    refill($urandom, 3, 1, -1, LW - 1, 1'b0);
    // error response on beat 2, then a clean refill
    refill($urandom, 0, 0, 2, LW - 1, 1'b0);
    refill($urandom, 0, 0, -1, LW - 1, 1'b0);
    // rlast on beat 1
    refill($urandom, 0, 0, -1, 1, 1'b0);
    // back-to-back request to 0x40
    refill(32'h0000_0040, 0, 0, -1, LW - 1, 1'b0);
    // reset in the middle of a burst, then a normal refill
    reset_mid_burst();
    refill($urandom, 1, 2, -1, LW - 1, 1'b0);

    // randomized refills
    for (int n = 0; n < 25; n++) begin
      int eb, lb;
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
      lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LW)) : LW - 1;
      refill($urandom, int'($urandom_range(0, 3)), 2, eb, lb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
